// File: rtl/alu_pkg.sv
`timescale 1ns/1ps
// Shared opcodes, FSM state encoding and default datapath width for the accumulator ALU.
package alu_pkg;

    localparam int ALU_WIDTH = 8;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_MUL = 2'b10;
    localparam logic [1:0] OP_DIV = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/alu_muldiv_iter.sv
`timescale 1ns/1ps
// Iterative unsigned MUL (shift-add) / DIV (restoring), one bit per cycle.
// Latency: WIDTH cycles after start; result/done are valid combinationally on the last iteration.
// No backpressure: start is only issued by the owning FSM while this unit is idle.
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic [WIDTH-1:0] result,
    output logic             done
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic             busy;
    logic             is_div;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] part;   // MUL: running product, DIV: partial remainder
    logic [WIDTH-1:0] sh;     // MUL: shifted multiplicand, DIV: dividend shifting into quotient
    logic [WIDTH-1:0] opnd;   // MUL: multiplier (shifts right), DIV: divisor (constant)

    logic [WIDTH-1:0] part_nxt;
    logic [WIDTH-1:0] sh_nxt;
    logic [WIDTH-1:0] opnd_nxt;
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH:0]   diff;

    always_comb begin
        part_nxt = part;
        sh_nxt   = sh;
        opnd_nxt = opnd;
        rem_sh   = '0;
        diff     = '0;
        if (is_div) begin
            // A zero divisor never restores, so the quotient naturally saturates to all ones.
            rem_sh = {part, sh[WIDTH-1]};
            diff   = rem_sh - {1'b0, opnd};
            if (!diff[WIDTH]) begin
                part_nxt = diff[WIDTH-1:0];
                sh_nxt   = {sh[WIDTH-2:0], 1'b1};
            end else begin
                part_nxt = rem_sh[WIDTH-1:0];
                sh_nxt   = {sh[WIDTH-2:0], 1'b0};
            end
        end else begin
            part_nxt = part + (opnd[0] ? sh : '0);
            sh_nxt   = sh << 1;
            opnd_nxt = opnd >> 1;
        end
    end

    assign result = is_div ? sh_nxt : part_nxt;
    assign done   = busy && (cnt == LAST);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            busy   <= 1'b0;
            is_div <= 1'b0;
            cnt    <= '0;
            part   <= '0;
            sh     <= '0;
            opnd   <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            is_div <= (op == OP_DIV);
            cnt    <= '0;
            part   <= '0;
            sh     <= a;
            opnd   <= b;
        end else if (busy) begin
            part <= part_nxt;
            sh   <= sh_nxt;
            opnd <= opnd_nxt;
            cnt  <= cnt + CW'(1);
            busy <= (cnt != LAST);
        end
    end

endmodule

// File: rtl/alu_unit.sv
`timescale 1ns/1ps
// Accumulator ALU: acc <= acc op in for ADD/SUB/MUL/DIV, with a one-cycle ready pulse.
// Latency: ADD/SUB complete at the accepting edge, MUL/DIV WIDTH edges later.
// valid is only sampled in IDLE; commands arriving while busy are dropped, not queued.
module alu_unit
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
)
(
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] in,
    input  logic [1:0]       op_codes,
    input  logic             valid,
    output logic [WIDTH-1:0] o,
    output logic             ready
);

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic             md_start;
    logic [WIDTH-1:0] md_result;
    logic             md_done;

    assign md_start = (state == ST_IDLE) && valid && op_codes[1];
    assign o        = acc;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (op_codes),
        .a      (acc),
        .b      (in),
        .result (md_result),
        .done   (md_done)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= ST_IDLE;
            acc   <= '0;
            ready <= 1'b0;
        end else begin
            ready <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (valid) begin
                        case (op_codes)
                            OP_ADD: begin
                                acc   <= acc + in;
                                ready <= 1'b1;
                                state <= ST_DONE;
                            end
                            OP_SUB: begin
                                acc   <= acc - in;
                                ready <= 1'b1;
                                state <= ST_DONE;
                            end
                            default: state <= ST_EXEC;
                        endcase
                    end
                end
                // The final iteration and the accumulator write share one edge.
                ST_EXEC: begin
                    if (md_done) begin
                        acc   <= md_result;
                        ready <= 1'b1;
                        state <= ST_DONE;
                    end
                end
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_unit.sv
`timescale 1ns/1ps
// Directed bench for alu_unit: hand-computed results, latency and ready-pulse checks.
module tb_alu_unit;
    import alu_pkg::*;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic [W-1:0] in_b = '0;
    logic [1:0]   op_codes = 2'b00;
    logic         valid = 1'b0;
    logic [W-1:0] o;
    logic         ready;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    alu_unit #(.WIDTH(W)) dut (
        .clk      (clk),
        .rst      (rst),
        .in       (in_b),
        .op_codes (op_codes),
        .valid    (valid),
        .o        (o),
        .ready    (ready)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Issue one command, then scramble in/op_codes so late changes would be visible.
    task automatic run_cmd(input string tag, input logic [1:0] op, input logic [7:0] b,
                           input logic [7:0] exp_o, input int exp_lat);
        int k;
        @(negedge clk);
        valid    = 1'b1;
        op_codes = op;
        in_b     = b;
        @(posedge clk);
        #1;
        valid    = 1'b0;
        in_b     = ~b;
        op_codes = ~op;
        k = 0;
        while (ready !== 1'b1 && k < 20) begin
            @(posedge clk);
            #1;
            k++;
        end
        check_val({tag, "_lat"}, k, exp_lat);
        check_val({tag, "_o"}, {24'd0, o}, {24'd0, exp_o});
        @(posedge clk);
        #1;
        check_val({tag, "_rdy_fall"}, {31'd0, ready}, 32'd0);
    endtask

    initial begin
        int pulses;
        int at;

        #1;
        check_val("rst_o", {24'd0, o}, 32'd0);
        check_val("rst_ready", {31'd0, ready}, 32'd0);
        #20;
        @(negedge clk);
        rst = 1'b1;

        run_cmd("add5",   OP_ADD, 8'd5,   8'd5,   0);
        run_cmd("sub10",  OP_SUB, 8'd10,  8'd251, 0);
        run_cmd("mul3",   OP_MUL, 8'd3,   8'd241, 8);
        run_cmd("div15",  OP_DIV, 8'd15,  8'd16,  8);
        run_cmd("div0",   OP_DIV, 8'd0,   8'd255, 8);

        // valid held high with in/op_codes changing during EXEC: 255*2 = 510 -> 254
        @(negedge clk);
        valid    = 1'b1;
        op_codes = OP_MUL;
        in_b     = 8'd2;
        @(posedge clk);
        #1;
        pulses = 0;
        at     = -1;
        for (int i = 1; i <= 9; i++) begin
            @(negedge clk);
            in_b     = 8'(i * 37);
            op_codes = 2'(i);
            @(posedge clk);
            #1;
            if (ready === 1'b1) begin
                pulses++;
                at = i;
            end
        end
        @(negedge clk);
        valid = 1'b0;
        check_val("hold_pulses", pulses, 1);
        check_val("hold_pulse_at", at, 8);
        check_val("hold_o", {24'd0, o}, 32'd254);
        @(posedge clk);
        #1;

        run_cmd("add3_wrap", OP_ADD, 8'd3,   8'd1,   0);
        run_cmd("div7_small", OP_DIV, 8'd7,  8'd0,   8);
        run_cmd("sub1_wrap", OP_SUB, 8'd1,   8'd255, 0);
        run_cmd("mul255",    OP_MUL, 8'd255, 8'd1,   8);
        run_cmd("div1",      OP_DIV, 8'd1,   8'd1,   8);

        // Reset mid-MUL: outputs clear without a clock edge and no ready follows
        @(negedge clk);
        valid    = 1'b1;
        op_codes = OP_MUL;
        in_b     = 8'd5;
        @(posedge clk);
        #1;
        valid = 1'b0;
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        check_val("arst_o", {24'd0, o}, 32'd0);
        check_val("arst_ready", {31'd0, ready}, 32'd0);
        @(negedge clk);
        rst = 1'b1;
        pulses = 0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (ready === 1'b1) pulses++;
        end
        check_val("arst_no_ready", pulses, 0);
        check_val("arst_o_hold", {24'd0, o}, 32'd0);

        run_cmd("add9_after_rst", OP_ADD, 8'd9, 8'd9, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
